// File: rtl/mem_arbiter_pkg.sv
// Shared types for mem_arbiter: FSM states, owner encoding and bus width.
// MEM_ARB_ROUND_ROBIN_EN (optional) selects round-robin arbitration in the users of this package.
`ifndef REG_BUS_D
`define REG_BUS_D 32
`endif

package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StResp = 2'd2
    } state_e;

    typedef enum logic {
        OwnerIf  = 1'b0,
        OwnerLsu = 1'b1
    } owner_e;

    localparam logic [3:0] FetchSel = 4'b1111;
    localparam logic [3:0] NoSel    = 4'b0000;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner selection between fetch and LSU.
// MEM_ARB_ROUND_ROBIN_EN: alternate on contention using last_grant_i; otherwise LSU has priority.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic   if_req_i,
    input  logic   lsu_req_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  owner_e last_grant_i,
`endif
    output owner_e winner_o
);

    always_comb begin
        winner_o = OwnerLsu;
        if (if_req_i && !lsu_req_i) begin
            winner_o = OwnerIf;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        end else if (if_req_i && lsu_req_i && (last_grant_i == OwnerLsu)) begin
            winner_o = OwnerIf;
`endif
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding bus arbiter between instruction fetch and LSU.
// MEM_ARB_ROUND_ROBIN_EN enables the last_grant register and round-robin contention handling.
`ifndef REG_BUS_D
`define REG_BUS_D 32
`endif

module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    if_req_i,
    input  logic [`REG_BUS_D-1:0]   if_addr_i,
    output logic [`REG_BUS_D-1:0]   if_rdata_o,
    output logic                    if_rvalid_o,
    output logic                    if_err_o,
    output logic                    if_stall_o,
    input  logic                    lsu_req_i,
    input  logic                    lsu_we_i,
    input  logic [`REG_BUS_D-1:0]   lsu_addr_i,
    input  logic [3:0]              lsu_sel_i,
    input  logic [`REG_BUS_D-1:0]   lsu_wdata_i,
    output logic [`REG_BUS_D-1:0]   lsu_rdata_o,
    output logic                    lsu_rvalid_o,
    output logic                    lsu_err_o,
    output logic                    lsu_stall_o,
    output logic                    bus_req_o,
    output logic                    bus_we_o,
    output logic [`REG_BUS_D-1:0]   bus_addr_o,
    output logic [3:0]              bus_sel_o,
    output logic [`REG_BUS_D-1:0]   bus_wdata_o,
    input  logic                    bus_gnt_i,
    input  logic                    bus_rvalid_i,
    input  logic [`REG_BUS_D-1:0]   bus_rdata_i,
    input  logic                    bus_err_i
);

    state_e                  state_q, state_d;
    owner_e                  owner_q, owner_d;
    logic                    bus_req_q, bus_req_d;
    logic                    bus_we_q, bus_we_d;
    logic [`REG_BUS_D-1:0]   bus_addr_q, bus_addr_d;
    logic [3:0]              bus_sel_q, bus_sel_d;
    logic [`REG_BUS_D-1:0]   bus_wdata_q, bus_wdata_d;
    owner_e                  winner;
    logic                    any_req;
    logic                    resp_fire;
    logic [`REG_BUS_D-1:0]   resp_data;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_e                  last_grant_q, last_grant_d;
`endif

    assign any_req = if_req_i | lsu_req_i;

    arb_pick u_arb_pick (
        .if_req_i     (if_req_i),
        .lsu_req_i    (lsu_req_i),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_grant_i (last_grant_q),
`endif
        .winner_o     (winner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_sel_d   = bus_sel_q;
        bus_wdata_d = bus_wdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d   = StReq;
                    owner_d   = winner;
                    bus_req_d = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_grant_d = winner;
`endif
                    if (winner == OwnerLsu) begin
                        bus_we_d    = lsu_we_i;
                        bus_addr_d  = lsu_addr_i;
                        bus_sel_d   = lsu_sel_i;
                        bus_wdata_d = lsu_wdata_i;
                    end else begin
                        bus_we_d    = 1'b0;
                        bus_addr_d  = if_addr_i;
                        bus_sel_d   = FetchSel;
                        bus_wdata_d = '0;
                    end
                end
            end
            StReq: begin
                if (bus_gnt_i) begin
                    state_d   = StResp;
                    bus_req_d = 1'b0;
                end
            end
            StResp: begin
                if (bus_rvalid_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d   = StIdle;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            owner_q     <= OwnerIf;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_sel_q   <= NoSel;
            bus_wdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= OwnerIf;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_sel_o   = bus_sel_q;
    assign bus_wdata_o = bus_wdata_q;

    // Responses are steered combinationally so the owner sees rvalid in the bus ack cycle.
    assign resp_fire = (state_q == StResp) & bus_rvalid_i;
    assign resp_data = bus_err_i ? '0 : bus_rdata_i;

    assign if_rvalid_o  = resp_fire & (owner_q == OwnerIf);
    assign lsu_rvalid_o = resp_fire & (owner_q == OwnerLsu);
    assign if_err_o     = if_rvalid_o & bus_err_i;
    assign lsu_err_o    = lsu_rvalid_o & bus_err_i;
    assign if_rdata_o   = if_rvalid_o ? resp_data : '0;
    assign lsu_rdata_o  = lsu_rvalid_o ? resp_data : '0;

    assign if_stall_o  = if_req_i & ~if_rvalid_o;
    assign lsu_stall_o = lsu_req_i & ~lsu_rvalid_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, hand sequences and randomized transactions.
// Expectations for contention follow MEM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_rvalid_o, if_err_o, if_stall_o;
    logic        lsu_req_i, lsu_we_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic [3:0]  lsu_sel_i;
    logic [31:0] lsu_rdata_o;
    logic        lsu_rvalid_o, lsu_err_o, lsu_stall_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic        bus_gnt_i, bus_rvalid_i, bus_err_i;
    logic [31:0] bus_rdata_i;

    always #5 clk_i = ~clk_i;

    mem_arbiter dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_rdata_o   (if_rdata_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_err_o     (if_err_o),
        .if_stall_o   (if_stall_o),
        .lsu_req_i    (lsu_req_i),
        .lsu_we_i     (lsu_we_i),
        .lsu_addr_i   (lsu_addr_i),
        .lsu_sel_i    (lsu_sel_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .lsu_rdata_o  (lsu_rdata_o),
        .lsu_rvalid_o (lsu_rvalid_o),
        .lsu_err_o    (lsu_err_o),
        .lsu_stall_o  (lsu_stall_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_sel_o    (bus_sel_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i),
        .bus_err_i    (bus_err_i)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_e last_model;
`endif

    typedef struct {
        logic        ireq;
        logic        lreq;
        logic [31:0] iaddr;
        logic [31:0] laddr;
        logic        lwe;
        logic [3:0]  lsel;
        logic [31:0] lwdata;
        int          gnt_dly;
        int          rv_dly;
        logic        err;
        logic [31:0] rdata;
        owner_e      exp;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_model = OwnerIf;
`endif
    endtask

    // Arbitration rule from the bench's point of view; records the grant for round-robin.
    function automatic owner_e model_pick(input logic ir, input logic lr);
        owner_e w;
        if (ir && !lr) w = OwnerIf;
        else if (lr && !ir) w = OwnerLsu;
        else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            w = (last_model == OwnerLsu) ? OwnerIf : OwnerLsu;
`else
            w = OwnerLsu;
`endif
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_model = w;
`endif
        return w;
    endfunction

    // One transaction starting in IDLE with requests already driven; the bench acts as bus slave.
    task automatic run_txn(input owner_e exp_owner, input int gnt_dly, input int rv_dly,
                           input logic err, input logic [31:0] rdata, input logic drop);
        logic [31:0] ea, ew;
        logic        ewe, fire, fi, fl;
        logic [3:0]  es;
        if (exp_owner == OwnerIf) begin
            ea = if_addr_i; ewe = 1'b0; es = 4'b1111; ew = 32'h0;
        end else begin
            ea = lsu_addr_i; ewe = lsu_we_i; es = lsu_sel_i; ew = lsu_wdata_i;
        end
        sample();
        check("idle bus_req", bus_req_o, 1'b0);
        check("idle if_stall", if_stall_o, if_req_i);
        check("idle lsu_stall", lsu_stall_o, lsu_req_i);
        step();
        if (drop) begin
            if_req_i  = 1'b0;
            lsu_req_i = 1'b0;
        end
        for (int k = 0; k <= gnt_dly; k++) begin
            bus_gnt_i = (k == gnt_dly);
            sample();
            check("req bus_req", bus_req_o, 1'b1);
            check("req bus_addr", bus_addr_o, ea);
            check("req bus_we", bus_we_o, ewe);
            check("req bus_sel", bus_sel_o, es);
            check("req bus_wdata", bus_wdata_o, ew);
            check("req rvalids", {if_rvalid_o, lsu_rvalid_o}, 2'b00);
            check("req if_stall", if_stall_o, if_req_i);
            check("req lsu_stall", lsu_stall_o, lsu_req_i);
            step();
        end
        bus_gnt_i = 1'b0;
        for (int k = 0; k <= rv_dly; k++) begin
            fire = (k == rv_dly);
            fi = fire && (exp_owner == OwnerIf);
            fl = fire && (exp_owner == OwnerLsu);
            bus_rvalid_i = fire;
            bus_err_i    = err;
            bus_rdata_i  = rdata;
            sample();
            check("resp bus_req", bus_req_o, 1'b0);
            check("resp if_rvalid", if_rvalid_o, fi);
            check("resp lsu_rvalid", lsu_rvalid_o, fl);
            check("resp if_rdata", if_rdata_o, (fi && !err) ? rdata : 32'h0);
            check("resp lsu_rdata", lsu_rdata_o, (fl && !err) ? rdata : 32'h0);
            check("resp if_err", if_err_o, fi && err);
            check("resp lsu_err", lsu_err_o, fl && err);
            check("resp if_stall", if_stall_o, if_req_i && !fi);
            check("resp lsu_stall", lsu_stall_o, lsu_req_i && !fl);
            step();
        end
        bus_rvalid_i = 1'b0;
        bus_err_i    = 1'b0;
    endtask

    initial begin
        owner_e hold_exp[4];
        logic [1:0] rq;
        owner_e e;

        vecs[0] = '{1'b0, 1'b1, 32'h0, 32'h100, 1'b0, 4'hF, 32'h0, 0, 0, 1'b0, 32'hDEADBEEF, OwnerLsu};
        vecs[1] = '{1'b0, 1'b1, 32'h0, 32'h204, 1'b1, 4'hF, 32'h12345678, 3, 1, 1'b0, 32'h0, OwnerLsu};
        vecs[2] = '{1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 4'h0, 32'h0, 1, 2, 1'b1, 32'hBAD0BAD0, OwnerIf};
        vecs[3] = '{1'b1, 1'b0, 32'h84, 32'h0, 1'b0, 4'h0, 32'h0, 0, 0, 1'b0, 32'h00000013, OwnerIf};
        vecs[4] = '{1'b0, 1'b1, 32'h0, 32'h301, 1'b1, 4'b0010, 32'h0000AB00, 2, 0, 1'b0, 32'h1, OwnerLsu};

        rst_i = 1'b1; if_req_i = 1'b0; if_addr_i = '0; lsu_req_i = 1'b0; lsu_we_i = 1'b0;
        lsu_addr_i = '0; lsu_sel_i = '0; lsu_wdata_i = '0; bus_gnt_i = 1'b0;
        bus_rvalid_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = '0;
        step();
        do_reset();
        sample();
        check("reset bus_req", bus_req_o, 1'b0);
        check("reset bus_we", bus_we_o, 1'b0);
        check("reset bus_addr", bus_addr_o, 32'h0);
        check("reset bus_sel", bus_sel_o, 4'h0);
        check("reset bus_wdata", bus_wdata_o, 32'h0);
        check("reset rvalids", {if_rvalid_o, lsu_rvalid_o, if_err_o, lsu_err_o}, 4'h0);
        step();

        // Contention after reset: LSU first, then fetch, fetch stalled throughout.
        if_req_i = 1'b1; if_addr_i = 32'h40;
        lsu_req_i = 1'b1; lsu_addr_i = 32'h200; lsu_we_i = 1'b0; lsu_sel_i = 4'hF;
        run_txn(OwnerLsu, 0, 0, 1'b0, 32'hCAFE0001, 1'b0);
        lsu_req_i = 1'b0;
        run_txn(OwnerIf, 0, 0, 1'b0, 32'hCAFE0002, 1'b0);
        if_req_i = 1'b0;

        foreach (vecs[i]) begin
            if_req_i = vecs[i].ireq;   if_addr_i = vecs[i].iaddr;
            lsu_req_i = vecs[i].lreq;  lsu_addr_i = vecs[i].laddr;
            lsu_we_i = vecs[i].lwe;    lsu_sel_i = vecs[i].lsel;
            lsu_wdata_i = vecs[i].lwdata;
            run_txn(vecs[i].exp, vecs[i].gnt_dly, vecs[i].rv_dly, vecs[i].err, vecs[i].rdata,
                    1'b0);
            if_req_i = 1'b0;
            lsu_req_i = 1'b0;
        end

        // Held contention after reset.
        do_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        hold_exp = '{OwnerLsu, OwnerIf, OwnerLsu, OwnerIf};
`else
        hold_exp = '{OwnerLsu, OwnerLsu, OwnerLsu, OwnerLsu};
`endif
        if_req_i = 1'b1; if_addr_i = 32'h1000;
        lsu_req_i = 1'b1; lsu_addr_i = 32'h2000; lsu_we_i = 1'b1; lsu_sel_i = 4'h3;
        lsu_wdata_i = 32'h55AA;
        for (int i = 0; i < 4; i++) run_txn(hold_exp[i], 0, 0, 1'b0, 32'h100 + i, 1'b0);
        if_req_i = 1'b0;
        lsu_req_i = 1'b0;

        // Reset while waiting for the response: the late rvalid must be ignored.
        if_req_i = 1'b1; if_addr_i = 32'h90;
        step();
        bus_gnt_i = 1'b1;
        step();
        bus_gnt_i = 1'b0;
        sample();
        check("pre-rst bus_addr", bus_addr_o, 32'h90);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0; if_req_i = 1'b0;
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h5555;
        sample();
        check("post-rst if_rvalid", if_rvalid_o, 1'b0);
        check("post-rst lsu_rvalid", lsu_rvalid_o, 1'b0);
        check("post-rst bus_req", bus_req_o, 1'b0);
        check("post-rst bus_addr", bus_addr_o, 32'h0);
        check("post-rst bus_sel", bus_sel_o, 4'h0);
        step();
        bus_rvalid_i = 1'b0;
        lsu_req_i = 1'b1; lsu_addr_i = 32'h400; lsu_we_i = 1'b0; lsu_sel_i = 4'hF;
        run_txn(OwnerLsu, 0, 0, 1'b0, 32'h77, 1'b0);
        lsu_req_i = 1'b0;

        // Randomized transactions against the arbitration model.
        do_reset();
        for (int n = 0; n < 150; n++) begin
            rq = 2'($urandom_range(1, 3));
            if_req_i = rq[0];  if_addr_i = $urandom;
            lsu_req_i = rq[1]; lsu_addr_i = $urandom;
            lsu_we_i = 1'($urandom_range(0, 1));
            lsu_sel_i = 4'($urandom_range(1, 15));
            lsu_wdata_i = $urandom;
            e = model_pick(rq[0], rq[1]);
            run_txn(e, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 3) == 0));
            if_req_i = 1'b0;
            lsu_req_i = 1'b0;
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
